// File: rtl/dual_bram_pkg.sv
// Shared definitions for the dual_bram_be buffer store: read-during-write
// mode codes, clear-sweep state type and lane-count helpers.
package dual_bram_pkg;

    // Same-address read-during-write behaviour selectors
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // States of the post-reset clear sweep
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    // Number of write-enable lanes in a data word
    function automatic int calc_nlanes(input int width, input int lane_w);
        return width / lane_w;
    endfunction

    // A word must split into a whole number of lanes
    function automatic bit lanes_ok(input int width, input int lane_w);
        return (lane_w > 0) && ((width % lane_w) == 0);
    endfunction

endpackage

// File: rtl/dual_bram_clear_fsm.sv
// Post-reset clear sweep for dual_bram_be. Compiled only when the macro
// DUAL_BRAM_CLEAR_EN is defined. After reset it walks every address once,
// asking the top to write zero there, and holds busy high until done.
`ifdef DUAL_BRAM_CLEAR_EN
module dual_bram_clear_fsm
    import dual_bram_pkg::*;
#(
    parameter int LOG_DEP = 6
)(
    input  logic               clock,
    input  logic               reset,
    output logic               busy,
    output logic               clr_wen,
    output logic [LOG_DEP-1:0] clr_addr
);

    // One extra bit so reaching DEPTH is distinguishable from address 0
    localparam logic [LOG_DEP:0] TERM = {1'b1, {LOG_DEP{1'b0}}};

    clr_state_t       state_q, state_d;
    logic [LOG_DEP:0] cnt_q, cnt_d;

    // Advance the sweep address; leave CLEAR once the last address is written
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == TERM) begin
                state_d = IDLE;
            end
        end
    end

    // Reset (also mid-sweep) restarts the sweep from address 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_wen  = (state_q == CLEAR);
    assign clr_addr = cnt_q[LOG_DEP-1:0];

endmodule
`endif

// File: rtl/dual_bram_be.sv
// Simple dual-port block RAM with per-lane write enables, selectable
// read-during-write behaviour, optional output register and read-valid
// tracking. Router input-queue flit store.
// Optional feature: define DUAL_BRAM_CLEAR_EN to zero the array after every
// reset (busy is high during the sweep); otherwise busy is tied low and the
// array contents survive reset.
module dual_bram_be
    import dual_bram_pkg::*;
#(
    parameter int WIDTH    = 36,
    parameter int LOG_DEP  = 6,
    parameter int LANE_W   = 9,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
)(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      wen,
    input  logic [WIDTH/LANE_W-1:0]   wbe,
    input  logic [LOG_DEP-1:0]        waddr,
    input  logic [WIDTH-1:0]          din,
    input  logic                      ren,
    input  logic [LOG_DEP-1:0]        raddr,
    output logic [WIDTH-1:0]          dout,
    output logic                      rvalid,
    output logic                      busy
);

    localparam int NLANES = calc_nlanes(WIDTH, LANE_W);
    localparam int DEPTH  = 1 << LOG_DEP;

    if (!lanes_ok(WIDTH, LANE_W)) begin : g_bad_lanes
        $error("dual_bram_be: WIDTH must be a multiple of LANE_W");
    end
    if ((RDW_MODE != RDW_READ_FIRST) && (RDW_MODE != RDW_WRITE_FIRST)) begin : g_bad_rdw
        $error("dual_bram_be: RDW_MODE must be 0 or 1");
    end
    if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_bad_oreg
        $error("dual_bram_be: OUT_REG must be 0 or 1");
    end

    logic [WIDTH-1:0]   mem [DEPTH];

    logic               busy_w;
    logic               clr_wen;
    logic [LOG_DEP-1:0] clr_addr;

`ifdef DUAL_BRAM_CLEAR_EN
    dual_bram_clear_fsm #(
        .LOG_DEP (LOG_DEP)
    ) u_clear (
        .clock    (clock),
        .reset    (reset),
        .busy     (busy_w),
        .clr_wen  (clr_wen),
        .clr_addr (clr_addr)
    );
`else
    assign busy_w   = 1'b0;
    assign clr_wen  = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = busy_w;

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = enable & wen & ~busy_w;
    assign rd_acc = enable & ren & ~busy_w;

    logic [NLANES-1:0]  port_be;
    logic [LOG_DEP-1:0] port_addr;
    logic [WIDTH-1:0]   port_data;

    // Single physical write port: the clear sweep owns it while busy
    always_comb begin
        port_be   = '0;
        port_addr = waddr;
        port_data = din;
        if (clr_wen) begin
            port_be   = '1;
            port_addr = clr_addr;
            port_data = '0;
        end else if (wr_acc) begin
            port_be   = wbe;
        end
    end

    // Lane-masked array write; no reset here so the array maps to block RAM
    always_ff @(posedge clock) begin
        for (int i = 0; i < NLANES; i++) begin
            if (port_be[i]) begin
                mem[port_addr][i*LANE_W +: LANE_W] <= port_data[i*LANE_W +: LANE_W];
            end
        end
    end

    logic [WIDTH-1:0] rd_word;

    if (RDW_MODE == RDW_WRITE_FIRST) begin : g_write_first
        // Same-address collision returns the merged word: new lanes over old
        always_comb begin
            rd_word = mem[raddr];
            if (wr_acc && (waddr == raddr)) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (wbe[i]) begin
                        rd_word[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end else begin : g_read_first
        // Array read sees pre-write contents, giving old data on a collision
        assign rd_word = mem[raddr];
    end

    logic [WIDTH-1:0] dout_p1_q;
    logic             vld_p1_q;

    // ---- stage p1: array read register; data only loads on an accepted read
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_p1_q <= '0;
            vld_p1_q  <= 1'b0;
        end else if (enable) begin
            vld_p1_q <= rd_acc;
            if (rd_acc) begin
                dout_p1_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [WIDTH-1:0] dout_p2_q;
        logic             vld_p2_q;

        // ---- stage p2: optional output register, valid follows data
        always_ff @(posedge clock) begin
            if (reset) begin
                dout_p2_q <= '0;
                vld_p2_q  <= 1'b0;
            end else if (enable) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    dout_p2_q <= dout_p1_q;
                end
            end
        end

        assign dout   = dout_p2_q;
        assign rvalid = vld_p2_q;
    end else begin : g_no_out_reg
        assign dout   = dout_p1_q;
        assign rvalid = vld_p1_q;
    end

endmodule

// File: tb/tb_dual_bram_be.sv
// Bench for dual_bram_be: two instances share one stimulus stream
// (A: read-first, no output register; B: write-through, output register).
// Build with DUAL_BRAM_CLEAR_EN defined to include the clear-sweep sequences.
module tb_dual_bram_be;

    localparam int W  = 36;
    localparam int LD = 4;
    localparam int LW = 9;
    localparam int NL = W / LW;
    localparam int DP = 1 << LD;

`ifdef DUAL_BRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          wen;
    logic [NL-1:0] wbe;
    logic [LD-1:0] waddr;
    logic [W-1:0]  din;
    logic          ren;
    logic [LD-1:0] raddr;
    logic [W-1:0]  dout_a, dout_b;
    logic          rvalid_a, rvalid_b;
    logic          busy_a, busy_b;

    always #5 clock = ~clock;

    dual_bram_be #(.WIDTH(W), .LOG_DEP(LD), .LANE_W(LW), .RDW_MODE(0), .OUT_REG(0)) dut_a (
        .clock (clock), .reset (reset), .enable (enable), .wen (wen), .wbe (wbe),
        .waddr (waddr), .din (din), .ren (ren), .raddr (raddr),
        .dout (dout_a), .rvalid (rvalid_a), .busy (busy_a)
    );

    dual_bram_be #(.WIDTH(W), .LOG_DEP(LD), .LANE_W(LW), .RDW_MODE(1), .OUT_REG(1)) dut_b (
        .clock (clock), .reset (reset), .enable (enable), .wen (wen), .wbe (wbe),
        .waddr (waddr), .din (din), .ren (ren), .raddr (raddr),
        .dout (dout_b), .rvalid (rvalid_b), .busy (busy_b)
    );

    typedef struct {
        logic          en;
        logic          rst;
        logic          we;
        logic [NL-1:0] be;
        logic [LD-1:0] wa;
        logic [W-1:0]  d;
        logic          re;
        logic [LD-1:0] ra;
        logic [W-1:0]  ea;   // expected read data, instance A
        logic [W-1:0]  eb;   // expected read data, instance B
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    // expected output state
    logic         sa, sb1, sb2;
    logic [W-1:0] exp_da, exp_db;
    logic         busy_m;
    int           cnt_m;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic vec_t mk(input logic en, input logic rst, input logic we,
                                input logic [NL-1:0] be, input logic [LD-1:0] wa,
                                input logic [W-1:0] d, input logic re,
                                input logic [LD-1:0] ra, input logic [W-1:0] ea,
                                input logic [W-1:0] eb);
        vec_t v;
        v.en = en; v.rst = rst; v.we = we; v.be = be; v.wa = wa; v.d = d;
        v.re = re; v.ra = ra; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    function automatic vec_t wr(input logic [LD-1:0] wa, input logic [NL-1:0] be, input logic [W-1:0] d);
        return mk(1'b1, 1'b0, 1'b1, be, wa, d, 1'b0, '0, '0, '0);
    endfunction

    function automatic vec_t rd(input logic [LD-1:0] ra, input logic [W-1:0] ea, input logic [W-1:0] eb);
        return mk(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, ra, ea, eb);
    endfunction

    function automatic vec_t wrd(input logic [LD-1:0] wa, input logic [NL-1:0] be, input logic [W-1:0] d,
                                 input logic [LD-1:0] ra, input logic [W-1:0] ea, input logic [W-1:0] eb);
        return mk(1'b1, 1'b0, 1'b1, be, wa, d, 1'b1, ra, ea, eb);
    endfunction

    function automatic vec_t idle();
        return mk(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endfunction

    function automatic vec_t rst_v();
        return mk(1'b1, 1'b1, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h required %h", nm, $time, act, exp);
        end
    endtask

    // Drive one cycle, advance the expected state at the edge, check at the falling edge
    task automatic step(input vec_t v);
        logic acc;
        reset = v.rst; enable = v.en; wen = v.we; wbe = v.be; waddr = v.wa;
        din = v.d; ren = v.re; raddr = v.ra;
        acc = v.en & v.re & ~busy_m;
        if (!v.rst && acc) begin
            qa.push_back(v.ea);
            qb.push_back(v.eb);
        end
        @(posedge clock);
        if (v.rst) begin
            qa.delete(); qb.delete();
            sa = 1'b0; sb1 = 1'b0; sb2 = 1'b0;
            exp_da = '0; exp_db = '0;
            busy_m = CLR_EN; cnt_m = 0;
        end else begin
            if (v.en) begin
                sa  = acc;
                sb2 = sb1;
                sb1 = acc;
                if (sa) begin
                    if (qa.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb_a_underflow @%0t: got empty queue, required a pending read", $time);
                    end else begin
                        exp_da = qa.pop_front();
                    end
                end
                if (sb2) begin
                    if (qb.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL sb_b_underflow @%0t: got empty queue, required a pending read", $time);
                    end else begin
                        exp_db = qb.pop_front();
                    end
                end
            end
            if (busy_m) begin
                cnt_m++;
                if (cnt_m == DP) busy_m = 1'b0;
            end
        end
        @(negedge clock);
        chk("rvalid_a", {35'b0, rvalid_a}, {35'b0, sa});
        chk("rvalid_b", {35'b0, rvalid_b}, {35'b0, sb2});
        chk("dout_a", dout_a, exp_da);
        chk("dout_b", dout_b, exp_db);
        chk("busy_a", {35'b0, busy_a}, {35'b0, busy_m});
        chk("busy_b", {35'b0, busy_b}, {35'b0, busy_m});
    endtask

    initial begin
        sa = 1'b0; sb1 = 1'b0; sb2 = 1'b0;
        exp_da = '0; exp_db = '0; busy_m = 1'b0; cnt_m = 0;

        step(rst_v());
        step(rst_v());
        repeat (DP + 1) step(idle());

        // Lane writes, RDW collisions, back-to-back reads, independent ports
        tbl.push_back(wr(4'd5, 4'hF, 36'hFFFFFFFFF));
        tbl.push_back(wr(4'd5, 4'b0101, 36'h000000000));
        tbl.push_back(rd(4'd5, 36'hFF803FE00, 36'hFF803FE00));
        tbl.push_back(wr(4'd3, 4'hF, 36'h111111111));
        tbl.push_back(wrd(4'd3, 4'hF, 36'h222222222, 4'd3, 36'h111111111, 36'h222222222));
        tbl.push_back(rd(4'd3, 36'h222222222, 36'h222222222));
        tbl.push_back(wr(4'd0, 4'hF, 36'h0000000AB));
        tbl.push_back(wr(4'd1, 4'hF, 36'h0000001CD));
        tbl.push_back(wr(4'd2, 4'hF, 36'h0000002EF));
        tbl.push_back(rd(4'd0, 36'h0000000AB, 36'h0000000AB));
        tbl.push_back(rd(4'd1, 36'h0000001CD, 36'h0000001CD));
        tbl.push_back(rd(4'd2, 36'h0000002EF, 36'h0000002EF));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(wrd(4'd3, 4'b1000, 36'h333333333, 4'd3, 36'h222222222, 36'h332222222));
        tbl.push_back(rd(4'd3, 36'h332222222, 36'h332222222));
        tbl.push_back(wr(4'd4, 4'hF, 36'h123456789));
        tbl.push_back(wrd(4'd3, 4'b0000, 36'hFFFFFFFFF, 4'd4, 36'h123456789, 36'h123456789));
        tbl.push_back(rd(4'd3, 36'h332222222, 36'h332222222));
        tbl.push_back(wrd(4'd6, 4'hF, 36'h5A5A5A5A5, 4'd4, 36'h123456789, 36'h123456789));
        tbl.push_back(rd(4'd6, 36'h5A5A5A5A5, 36'h5A5A5A5A5));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
        repeat (3) step(idle());

        // Enable stall: outputs hold, the blocked write must not land
        step(rd(4'd5, 36'hFF803FE00, 36'hFF803FE00));
        repeat (4) step(mk(1'b0, 1'b0, 1'b1, 4'hF, 4'd5, 36'h000000000, 1'b1, 4'd3, '0, '0));
        repeat (3) step(idle());
        step(rd(4'd5, 36'hFF803FE00, 36'hFF803FE00));
        repeat (3) step(idle());

        // Reset clears the outputs; memory survives unless the sweep is built in
        step(rst_v());
`ifdef DUAL_BRAM_CLEAR_EN
        repeat (DP) step(idle());
        step(rd(4'd5, 36'h000000000, 36'h000000000));
`else
        step(rd(4'd5, 36'hFF803FE00, 36'hFF803FE00));
`endif
        repeat (3) step(idle());

`ifdef DUAL_BRAM_CLEAR_EN
        // Full sweep: reads during busy are refused, everything reads 0 after
        for (int i = 0; i < DP; i++) step(wr(LD'(i), 4'hF, 36'hAAAAAAAAA));
        step(rd(4'd7, 36'hAAAAAAAAA, 36'hAAAAAAAAA));
        repeat (3) step(idle());
        step(rst_v());
        for (int i = 0; i < DP; i++) step(rd(LD'(i), 36'hAAAAAAAAA, 36'hAAAAAAAAA));
        for (int i = 0; i < DP; i++) step(rd(LD'(i), 36'h0, 36'h0));
        repeat (3) step(idle());

        // Reset at sweep count 7 restarts the full sweep
        for (int i = 0; i < DP; i++) step(wr(LD'(i), 4'hF, 36'hAAAAAAAAA));
        step(rst_v());
        repeat (7) step(idle());
        step(rst_v());
        for (int i = 0; i < DP; i++) step(rd(LD'(i), 36'hAAAAAAAAA, 36'hAAAAAAAAA));
        for (int i = 0; i < DP; i++) step(rd(LD'(i), 36'h0, 36'h0));
        repeat (3) step(idle());
`endif

        chk("sb_a_drained", W'(qa.size()), '0);
        chk("sb_b_drained", W'(qb.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
